// File: rtl/uart_loader.sv
// 8N1 UART receiver that packs bytes little-endian into 32-bit words for the boot-time memory download.
// Raises uart_done a fixed delay after the last word so the core leaves reset with memory fully written.
module uart_loader #(
  parameter int          CLKS_PER_BIT = 10417,
  parameter int          WORD_CNT     = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          DONE_DELAY   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] uart_data,
  output logic [31:0] uart_addr,
  output logic        uart_done,
  output logic        frame_err,
  output logic [15:0] word_idx
);

  localparam int CMAX = (CLKS_PER_BIT > DONE_DELAY) ? CLKS_PER_BIT : DONE_DELAY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_DD      = CW'(DONE_DELAY);
  localparam logic [15:0]   C_LAST    = 16'(WORD_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_HOLD, S_DONE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [1:0]    r_byte_cnt;
  logic [7:0]    r_b0;
  logic [7:0]    r_b1;
  logic [7:0]    r_b2;
  logic          w_rxs;

  assign w_rxs = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync     <= 2'b11;
      r_cnt      <= '0;
      r_bit      <= 3'd0;
      r_shift    <= 8'd0;
      r_byte_cnt <= 2'd0;
      r_b0       <= 8'd0;
      r_b1       <= 8'd0;
      r_b2       <= 8'd0;
      uart_data  <= 32'd0;
      uart_addr  <= BASE_ADDR;
      uart_done  <= 1'b0;
      frame_err  <= 1'b0;
      word_idx   <= 16'd0;
    end else begin
      r_sync <= {r_sync[0], rx};
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          // Mid-start-bit check; a line that is already high again was a glitch.
          if (r_cnt == C_HALF_M1) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_bit   <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == C_BIT_M1) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == C_BIT_M1) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (w_rxs) begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              case (r_byte_cnt)
                2'd0: r_b0 <= r_shift;
                2'd1: r_b1 <= r_shift;
                2'd2: r_b2 <= r_shift;
                default: begin
                  // Data and address move together so memory never sees a torn word.
                  uart_data <= {r_shift, r_b2, r_b1, r_b0};
                  uart_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                  word_idx  <= word_idx + 16'd1;
                  if (word_idx == C_LAST) r_state <= S_HOLD;
                end
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == C_DD) begin
            r_state   <= S_DONE;
            uart_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
